// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply-accumulate datapath.
package booth_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed add of a sign-extended Booth product to an ACC_W operand.
// BOOTH_ACC_SAT_EN selects clamping on overflow; otherwise the sum wraps.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    // One guard bit: overflow when the guard and the result sign disagree.
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
`ifdef BOOTH_ACC_SAT_EN
    if (ovf) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = wide[ACC_W-1:0];
    end
`else
    sum = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates BLOCK_LEN signed Booth products per block and hands the sum downstream.
// Build option BOOTH_ACC_SAT_EN: saturating accumulation instead of wrap-around.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               prod_valid,
  input  logic [PROD_W-1:0]                  finproduct,
  output logic                               prod_ready,
  input  logic                               clear,
  output logic                               acc_valid,
  input  logic                               out_ready,
  output logic [ACC_W-1:0]                   acc_sum,
  output logic [$clog2(BLOCK_LEN+1)-1:0]     acc_count,
  output logic                               overflow
);

  localparam int CNT_W = $clog2(BLOCK_LEN+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  acc_state_t       state;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  booth_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc  (acc_sum),
    .prod (finproduct),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCUM;
      acc_sum   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      acc_sum   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (prod_valid) begin
            acc_sum   <= add_sum;
            acc_count <= acc_count + ONE;
            overflow  <= overflow | add_ovf;
            if (acc_count == LAST) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            acc_sum   <= '0;
            acc_count <= '0;
            overflow  <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Randomized plus directed check of booth_product_accumulator against a block-level model.
module tb_booth_product_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prod_valid = 1'b0;
  logic [7:0] finproduct = '0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  // Three configurations driven from the same stimulus.
  logic [11:0] s0; logic [2:0] c0; logic pr0, av0, ov0;
  logic [7:0]  s1; logic [1:0] c1; logic pr1, av1, ov1;
  logic [11:0] s2; logic [0:0] c2; logic pr2, av2, ov2;

  booth_product_accumulator #(.ACC_W(12), .BLOCK_LEN(4)) dut0 (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .finproduct(finproduct),
    .prod_ready(pr0), .clear(clear), .acc_valid(av0), .out_ready(out_ready),
    .acc_sum(s0), .acc_count(c0), .overflow(ov0));

  booth_product_accumulator #(.ACC_W(8), .BLOCK_LEN(2)) dut1 (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .finproduct(finproduct),
    .prod_ready(pr1), .clear(clear), .acc_valid(av1), .out_ready(out_ready),
    .acc_sum(s1), .acc_count(c1), .overflow(ov1));

  booth_product_accumulator #(.ACC_W(12), .BLOCK_LEN(1)) dut2 (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .finproduct(finproduct),
    .prod_ready(pr2), .clear(clear), .acc_valid(av2), .out_ready(out_ready),
    .acc_sum(s2), .acc_count(c2), .overflow(ov2));

  always #5 clk = ~clk;

  logic [31:0] o_sum [3];
  logic [31:0] o_cnt [3];
  logic        o_pr  [3];
  logic        o_av  [3];
  logic        o_ov  [3];

  assign o_sum[0] = 32'(s0);
  assign o_sum[1] = 32'(s1);
  assign o_sum[2] = 32'(s2);
  assign o_cnt[0] = 32'(c0);
  assign o_cnt[1] = 32'(c1);
  assign o_cnt[2] = 32'(c2);
  assign o_pr[0] = pr0; assign o_pr[1] = pr1; assign o_pr[2] = pr2;
  assign o_av[0] = av0; assign o_av[1] = av1; assign o_av[2] = av2;
  assign o_ov[0] = ov0; assign o_ov[1] = ov1; assign o_ov[2] = ov2;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: block length, width, products counted in block, true sum, sticky flag.
  int L [3] = '{4, 2, 1};
  int W [3] = '{12, 8, 12};
  int m_cnt [3];
  int m_sum [3];
  bit m_ov  [3];

  function automatic void model_clear(input int i);
    m_cnt[i] = 0;
    m_sum[i] = 0;
    m_ov[i]  = 1'b0;
  endfunction

  function automatic void model_edge(input bit pv, input logic [7:0] p, input bit ordy, input bit clr);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        model_clear(i);
      end else if (m_cnt[i] == L[i]) begin
        if (ordy) model_clear(i);
      end else if (pv) begin
        int s, hi, lo;
        s  = m_sum[i] + int'($signed(p));
        hi = (1 << (W[i] - 1)) - 1;
        lo = -(1 << (W[i] - 1));
        if (s > hi || s < lo) begin
          m_ov[i] = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
          s = (s > hi) ? hi : lo;
`else
          s = ((s - lo) % (1 << W[i]) + (1 << W[i])) % (1 << W[i]) + lo;
`endif
        end
        m_sum[i] = s;
        m_cnt[i]++;
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int mask;
      mask = (1 << W[i]) - 1;
      check($sformatf("i%0d_sum", i),   o_sum[i], 32'(m_sum[i] & mask));
      check($sformatf("i%0d_count", i), o_cnt[i], 32'(m_cnt[i]));
      check($sformatf("i%0d_ovf", i),   32'(o_ov[i]), 32'(m_ov[i]));
      check($sformatf("i%0d_ready", i), 32'(o_pr[i]), 32'(m_cnt[i] < L[i]));
      check($sformatf("i%0d_valid", i), 32'(o_av[i]), 32'(m_cnt[i] == L[i]));
    end
  endtask

  task automatic step(input bit pv, input logic [7:0] p, input bit ordy, input bit clr);
    prod_valid = pv;
    finproduct = p;
    out_ready  = ordy;
    clear      = clr;
    @(posedge clk);
    model_edge(pv, p, ordy, clr);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) model_clear(i);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Basic block: -15, 7, 127, -128 sums to -9.
    step(1, 8'hF1, 1, 0);
    step(1, 8'h07, 1, 0);
    step(1, 8'h7F, 1, 0);
    step(1, 8'h80, 1, 0);
    check("basic_sum", 32'(s0), 32'h0FF7);
    check("basic_valid", 32'(av0), 32'd1);
    check("basic_count", 32'(c0), 32'd4);

    // Backpressure with a product held on the input.
    repeat (5) step(1, 8'd5, 0, 0);
    check("bp_sum", 32'(s0), 32'h0FF7);
    check("bp_ready", 32'(pr0), 32'd0);
    step(1, 8'd5, 1, 0);
    check("release_sum", 32'(s0), 32'd0);
    step(1, 8'd5, 1, 0);
    check("held_accept", 32'(s0), 32'd5);

    // Overflow on the 8-bit instance.
    step(0, 8'd0, 0, 1);
    step(1, 8'd127, 0, 0);
    step(1, 8'd127, 0, 0);
`ifdef BOOTH_ACC_SAT_EN
    check("ovf_sum", 32'(s1), 32'h7F);
`else
    check("ovf_sum", 32'(s1), 32'hFE);
`endif
    check("ovf_flag", 32'(ov1), 32'd1);

    // Clear mid-block drops the offered product.
    step(0, 8'd0, 1, 1);
    step(1, 8'd3, 1, 0);
    step(1, 8'd4, 1, 0);
    step(1, 8'd9, 1, 1);
    check("clear_sum", 32'(s0), 32'd0);
    check("clear_count", 32'(c0), 32'd0);

    // Reset between edges, mid-block.
    step(1, 8'd2, 1, 0);
    step(1, 8'd2, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_clear(i);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step(1, 8'd1, 0, 0);
    check("post_reset_sum", 32'(s0), 32'd4);

    // BLOCK_LEN=1 single product.
    step(0, 8'd0, 1, 1);
    step(1, 8'hFD, 1, 0);
    check("len1_sum", 32'(s2), 32'h0FFD);
    check("len1_valid", 32'(av2), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream consumer of the 4-bit Booth multiplier's 8-bit signed `finproduct`. It accepts one product per valid/ready handshake and accumulates a fixed-length block of products into a wider signed sum. It presents the block result to the next stage with a valid/ready handshake and tracks overflow. It forms the accumulate half of the team's Booth multiply-accumulate datapath.

## Interface
- `ACC_W`, 12: accumulator width in bits, signed, ≥ 8.
- `BLOCK_LEN`, 4: products per block, ≥ 1.
- `clk` input 1: single clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low; asserted when 0.
- `prod_valid` input 1: `finproduct` holds a new product.
- `finproduct` input 8: signed product from the Booth multiplier.
- `prod_ready` output 1: the block accepts a product this cycle.
- `clear` input 1: synchronous abort; discards the partial block.
- `acc_valid` output 1: `acc_sum` holds a complete block result.
- `out_ready` input 1: the downstream stage consumes the result.
- `acc_sum` output `ACC_W`: signed accumulated sum (register).
- `acc_count` output `$clog2(BLOCK_LEN+1)`: products accepted in the current block.
- `overflow` output 1: sticky; set when any add in the current block overflowed `ACC_W`.

## Operation
- States:
  - ACCUM: `prod_ready=1`, `acc_valid=0`.
  - HOLD: `prod_ready=0`, `acc_valid=1`.
- Accept condition: `prod_valid & prod_ready`.
- On accept:
  - `acc_sum <= acc_sum + sext(finproduct)`, with the add per Configuration.
  - `acc_count` increments.
  - `overflow` is set if the signed add overflows.
- Block completion: an accept with `acc_count == BLOCK_LEN-1` moves the FSM ACCUM→HOLD. The `acc_count` register then holds `BLOCK_LEN`.
- HOLD behaviour:
  - `acc_sum`, `acc_count` and `overflow` stay frozen.
  - `out_ready=1` → return to ACCUM; `acc_sum`, `acc_count` and `overflow` are zeroed on the same edge.
- Product arriving with a HOLD release: `prod_valid` during the HOLD cycle that sees `out_ready` is not accepted, because `prod_ready=0`. It is accepted on a later ACCUM cycle if still presented.
- `clear=1` in any state, on the next edge:
  - state → ACCUM;
  - `acc_sum`, `acc_count` and `overflow` → 0;
  - any product offered that cycle is dropped.
  - `clear` has priority over accept and over `out_ready`.
- Reset values (reset=0, immediately): state ACCUM, `acc_sum=0`, `acc_count=0`, `overflow=0`, `acc_valid=0`, `prod_ready=1`.
- Reset mid-block discards all partial state. There is no recovery of the partial sum.
- `BLOCK_LEN=1`: every accept moves the FSM directly to HOLD.

## Timing
- Registered outputs: `acc_sum`, `acc_count`, `overflow` and the state; they update on the edge of the accept.
- `prod_ready` and `acc_valid` are decoded from state only. There is no combinational path from `prod_valid`, `out_ready` or `clear` to any output.
- Completion latency: `acc_valid` rises the cycle after the `BLOCK_LEN`-th accept.
- Minimum block period: `BLOCK_LEN` + 1 cycles, when `out_ready` is held high.
- Hold duration: `acc_valid` stays high with stable `acc_sum` for as long as `out_ready=0`.
- Reset timing: assertion is asynchronous; deassertion is taken on the next rising edge of `clk`.

## Configuration
- Macro: `BOOTH_ACC_SAT_EN`.
- Defined: saturating add. On positive overflow `acc_sum` clamps to 2^(ACC_W-1)-1; on negative overflow it clamps to -2^(ACC_W-1). `overflow` is set in both cases.
- Undefined: two's-complement wrap-around modulo 2^ACC_W. `overflow` is still set on signed overflow.

## Structure
- Package `booth_pkg`: `PROD_W = 8`, and the state enum `acc_state_t {ACCUM, HOLD}`.
- Sub-module `booth_sat_add`:
  - combinational signed add of `sext(finproduct)` to an `ACC_W` operand;
  - outputs the sum and an overflow flag;
  - saturation is selected by `BOOTH_ACC_SAT_EN`.
- The FSM, counter and registers live in the top module.

## Test plan
- Basic block (`ACC_W=12`, `BLOCK_LEN=4`, `out_ready=1`): products 8'hF1 (-15), 7, 127, -128 → `acc_valid` the cycle after the 4th accept, `acc_sum=12'hFF7` (-9), `acc_count=4`, `overflow=0`.
- Backpressure: same block, `out_ready=0` for 5 cycles, `prod_valid` held with 5 → `prod_ready=0`, `acc_sum` stable at -9. Raise `out_ready` → next cycle ACCUM with `acc_sum=0`; the held 5 is accepted on the following edge.
- Overflow (`ACC_W=8`, `BLOCK_LEN=2`): products 127, 127 → with `BOOTH_ACC_SAT_EN`, `acc_sum=8'h7F`, `overflow=1`; without it, `acc_sum=8'hFE`, `overflow=1`.
- Clear mid-block: accept 3, 4, then `clear=1` together with `prod_valid` carrying 9 → `acc_sum=0`, `acc_count=0`, the 9 is dropped, and the next block sums from zero.
- Reset mid-block: accept 2 products, drive `reset=0` between edges → all outputs at reset values immediately. After release, a 4-product block of 1s gives `acc_sum=4`.
- `BLOCK_LEN=1`: product -3 → `acc_valid` next cycle with `acc_sum=-3`; back-to-back operation with `out_ready=1` yields one result every 2 cycles.
